mux2_sel: RTL and testbench



---
 rtl/mux2_sel_pkg.sv | 9 +
 rtl/mux2_sel_dff_en_ar.sv | 22 ++
 rtl/mux2_sel.sv | 41 ++++
 tb/tb_mux2_sel.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux2_sel_pkg.sv
// Shared select encoding for the 2:1 word multiplexer and its registered stage.
package mux2_sel_pkg;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_e;

endpackage : mux2_sel_pkg

// File: rtl/mux2_sel_dff_en_ar.sv
// WIDTH-bit D flop with load enable and asynchronous active-high reset to RESET_VAL.
module mux2_sel_dff_en_ar #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset is checked first so it overrides en, even on a coincident edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : mux2_sel_dff_en_ar

// File: rtl/mux2_sel.sv
// Parameterised 2:1 word multiplexer with a zero-latency output and an optional
// registered copy for timing-critical consumers.
module mux2_sel
    import mux2_sel_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter bit               REG_OUT   = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
);

    // The conditional operator merges a and b bitwise on an unknown select,
    // so bits where both inputs agree stay known instead of going all-X.
    assign y = (s == SEL_B) ? b : a;

    generate
        if (REG_OUT) begin : g_reg_out
            mux2_sel_dff_en_ar #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_dff (
                .clk (clk),
                .rst (rst),
                .en  (en),
                .d   (y),
                .q   (y_q)
            );
        end else begin : g_comb_out
            assign y_q = y;
        end
    endgenerate

endmodule : mux2_sel

// File: tb/tb_mux2_sel.sv
// Scoreboard bench for mux2_sel: a registered 32-bit build and a combinational 8-bit build.
module tb_mux2_sel;

    logic        clk;
    logic        clk_run;
    logic        rst;
    logic        en;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] y;
    logic [31:0] y_q;

    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        s8;
    logic [7:0]  y8;
    logic [7:0]  y_q8;

    logic [31:0] model_q;
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    int          checks;
    int          errors;

    mux2_sel #(
        .WIDTH     (32),
        .REG_OUT   (1'b1),
        .RESET_VAL (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .s   (s),
        .en  (en),
        .y   (y),
        .y_q (y_q)
    );

    mux2_sel #(
        .WIDTH     (8),
        .REG_OUT   (1'b0),
        .RESET_VAL (8'h00)
    ) dut8 (
        .clk (clk),
        .rst (rst),
        .a   (a8),
        .b   (b8),
        .s   (s8),
        .en  (en),
        .y   (y8),
        .y_q (y_q8)
    );

    // Gated free-running clock so the reset test can run with no edges at all.
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Update the reference register from the inputs present before the edge,
    // queue the expectation, then step to just after the rising edge.
    task automatic clock_and_push();
        if (rst) model_q = '0;
        else if (en) model_q = s ? b : a;
        exp_q.push_back(model_q);
        @(posedge clk);
        #1;
    endtask

    task automatic test_comb();
        a = 32'hABCE_DF12;
        b = 32'h1234_5678;
        s = 1'b0;
        #1;
        checks++;
        if (y !== 32'hABCE_DF12) begin
            errors++;
            $display("[TB] FAIL comb_s0: y=%h expected=%h", y, 32'hABCE_DF12);
        end
        s = 1'b1;
        #1;
        checks++;
        if (y !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL comb_s1: y=%h expected=%h", y, 32'h1234_5678);
        end
        s = 1'b0;
        #1;
        checks++;
        if (y !== 32'hABCE_DF12) begin
            errors++;
            $display("[TB] FAIL comb_s0_again: y=%h expected=%h", y, 32'hABCE_DF12);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        model_q = '0;
        #1;
        checks++;
        if (y_q !== model_q) begin
            errors++;
            $display("[TB] FAIL reset_yq: y_q=%h expected=%h", y_q, model_q);
        end
        s = 1'b1;
        #1;
        checks++;
        if (y !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL reset_y_tracks: y=%h expected=%h", y, 32'h1234_5678);
        end
        checks++;
        if (y_q !== 32'h0000_0000) begin
            errors++;
            $display("[TB] FAIL reset_yq_held: y_q=%h expected=%h", y_q, 32'h0000_0000);
        end
    endtask

    task automatic test_capture();
        rst     = 1'b0;
        en      = 1'b1;
        s       = 1'b1;
        b       = 32'h1234_5678;
        clk_run = 1'b1;
        #1;
        checks++;
        if (y_q !== 32'h0000_0000) begin
            errors++;
            $display("[TB] FAIL capture_no_edge: y_q=%h expected=%h", y_q, 32'h0000_0000);
        end
        clock_and_push();
        exp = exp_q.pop_front();
        checks++;
        if (y_q !== exp) begin
            errors++;
            $display("[TB] FAIL capture_b: y_q=%h expected=%h", y_q, exp);
        end
        s = 1'b0;
        #1;
        checks++;
        if (y_q !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL capture_not_early: y_q=%h expected=%h", y_q, 32'h1234_5678);
        end
        clock_and_push();
        exp = exp_q.pop_front();
        checks++;
        if (y_q !== exp) begin
            errors++;
            $display("[TB] FAIL capture_a: y_q=%h expected=%h", y_q, exp);
        end
    endtask

    task automatic test_hold();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s = ~s;
            #1;
            checks++;
            if (y !== (s ? b : a)) begin
                errors++;
                $display("[TB] FAIL hold_y cycle %0d: y=%h expected=%h", i, y, (s ? b : a));
            end
            clock_and_push();
            exp = exp_q.pop_front();
            checks++;
            if (y_q !== exp || y_q !== 32'hABCE_DF12) begin
                errors++;
                $display("[TB] FAIL hold_yq cycle %0d: y_q=%h expected=%h", i, y_q, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        s  = 1'b1;
        clock_and_push();
        exp = exp_q.pop_front();
        checks++;
        if (y_q !== exp) begin
            errors++;
            $display("[TB] FAIL areset_pre: y_q=%h expected=%h", y_q, exp);
        end
        #2;
        rst     = 1'b1;
        model_q = '0;
        #1;
        checks++;
        if (y_q !== model_q) begin
            errors++;
            $display("[TB] FAIL areset_async: y_q=%h expected=%h", y_q, model_q);
        end
        rst = 1'b0;
        s   = 1'b0;
        #1;
        checks++;
        if (y_q !== 32'h0000_0000) begin
            errors++;
            $display("[TB] FAIL areset_release_wait: y_q=%h expected=%h", y_q, 32'h0000_0000);
        end
        clock_and_push();
        exp = exp_q.pop_front();
        checks++;
        if (y_q !== exp) begin
            errors++;
            $display("[TB] FAIL areset_resume: y_q=%h expected=%h", y_q, exp);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            a  = $urandom;
            b  = $urandom;
            s  = 1'($urandom_range(0, 1));
            en = (i % 4 == 3) ? 1'b0 : 1'b1;
            #1;
            checks++;
            if (y !== (s ? b : a)) begin
                errors++;
                $display("[TB] FAIL b2b_y %0d: y=%h expected=%h", i, y, (s ? b : a));
            end
            clock_and_push();
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL b2b_queue %0d: queue empty, expected one entry", i);
            end else begin
                exp = exp_q.pop_front();
                checks++;
                if (y_q !== exp) begin
                    errors++;
                    $display("[TB] FAIL b2b_yq %0d: y_q=%h expected=%h", i, y_q, exp);
                end
            end
        end
    endtask

    task automatic test_reg_out0();
        a8 = 8'hA5;
        b8 = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            s8 = i[0];
            #1;
            checks++;
            if (y8 !== (s8 ? 8'h5A : 8'hA5) || y_q8 !== (s8 ? 8'h5A : 8'hA5)) begin
                errors++;
                $display("[TB] FAIL w8_s%0d: y=%h y_q=%h expected=%h", i, y8, y_q8, (s8 ? 8'h5A : 8'hA5));
            end
        end
        a8 = 8'h3C;
        b8 = 8'h3C;
        s8 = 1'bx;
        #1;
        checks++;
        if (y8 !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL w8_sel_x: y=%h expected=%h", y8, 8'h3C);
        end
    endtask

    initial begin
        clk     = 1'b0;
        clk_run = 1'b0;
        rst     = 1'b0;
        en      = 1'b0;
        a       = '0;
        b       = '0;
        s       = 1'b0;
        a8      = '0;
        b8      = '0;
        s8      = 1'b0;
        model_q = '0;
        checks  = 0;
        errors  = 0;
        #1;
        test_comb();
        test_reset();
        test_capture();
        test_hold();
        test_async_reset();
        test_back_to_back();
        test_reg_out0();
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mux2_sel
